// File: rtl/i2c_reg_bridge.sv
// Register bank fed by an I2C slave byte stream (pointer byte, then auto-incrementing data bytes)
// with a host-side read/write port onto the same registers.
module i2c_reg_bridge #(
  parameter int ADDR_W  = 4,
  parameter int TIMEOUT = 1000
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  input  logic              tx_req,
  output logic [7:0]        tx_data,
  input  logic [ADDR_W-1:0] host_addr,
  input  logic              host_we,
  input  logic [7:0]        host_wdata,
  output logic [7:0]        host_rdata,
  output logic              wr_strobe,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [ADDR_W-1:0] ptr
);

  localparam int                NREG    = 1 << ADDR_W;
  localparam logic [15:0]       IDLE_TO = 16'(TIMEOUT);
  localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);

  typedef enum logic {
    S_PTR,
    S_DATA
  } state_t;

  state_t            state, state_nxt;
  logic              rx_prev, tx_prev;
  logic              rx_arm, tx_arm;
  logic              rx_evt, tx_evt;
  logic [7:0]        rx_byte;
  logic [15:0]       idle_cnt;
  logic [7:0]        regs [NREG];
  logic [ADDR_W-1:0] ptr_nxt;
  logic              data_we;
  logic              timed_out;
  logic              ptr_mode;

  // Arm flags block an edge until the input has been seen low, so a level
  // held high across reset never looks like a fresh byte.
  always_ff @(posedge clk) begin
    if (!reset) begin
      rx_prev <= 1'b0;
      tx_prev <= 1'b0;
      rx_arm  <= ~rx_valid;
      tx_arm  <= ~tx_req;
      rx_evt  <= 1'b0;
      tx_evt  <= 1'b0;
      rx_byte <= 8'h00;
    end else begin
      rx_prev <= rx_valid;
      tx_prev <= tx_req;
      rx_arm  <= rx_arm | ~rx_valid;
      tx_arm  <= tx_arm | ~tx_req;
      rx_evt  <= rx_valid & ~rx_prev & rx_arm;
      tx_evt  <= tx_req & ~tx_prev & tx_arm;
      if (rx_valid && !rx_prev) begin
        rx_byte <= rx_data;
      end
    end
  end

  assign timed_out = (idle_cnt == IDLE_TO);
  // A byte arriving on the very cycle the idle limit is reached is a pointer.
  assign ptr_mode  = (state == S_PTR) || timed_out;

  always_comb begin
    state_nxt = state;
    ptr_nxt   = ptr;
    data_we   = 1'b0;
    if (rx_evt) begin
      state_nxt = S_DATA;
      if (ptr_mode) begin
        ptr_nxt = rx_byte[ADDR_W-1:0];
      end else begin
        data_we = 1'b1;
        ptr_nxt = ptr + PTR_ONE;
      end
    end else if (tx_evt) begin
      ptr_nxt   = ptr + PTR_ONE;
      state_nxt = ptr_mode ? S_PTR : S_DATA;
    end else if (timed_out) begin
      state_nxt = S_PTR;
    end
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= S_PTR;
      ptr       <= '0;
      idle_cnt  <= 16'd0;
      wr_strobe <= 1'b0;
      wr_addr   <= '0;
    end else begin
      state     <= state_nxt;
      ptr       <= ptr_nxt;
      wr_strobe <= data_we;
      if (data_we) begin
        wr_addr <= ptr;
      end
      if (rx_evt || tx_evt) begin
        idle_cnt <= 16'd0;
      end else if (!timed_out) begin
        idle_cnt <= idle_cnt + 16'd1;
      end
    end
  end

  // I2C data write beats a host write to the same index.
  always_ff @(posedge clk) begin
    if (!reset) begin
      for (int i = 0; i < NREG; i++) begin
        regs[i] <= 8'h00;
      end
      host_rdata <= 8'h00;
    end else begin
      host_rdata <= regs[host_addr];
      if (host_we && !(data_we && (host_addr == ptr))) begin
        regs[host_addr] <= host_wdata;
      end
      if (data_we) begin
        regs[ptr] <= rx_byte;
      end
    end
  end

  assign tx_data = regs[ptr];

endmodule

// File: tb/tb_i2c_reg_bridge.sv
// Directed table plus randomized traffic for i2c_reg_bridge, checked against
// a transaction-level model of the pointer/data protocol.
module tb_i2c_reg_bridge;
  localparam int AW = 4;
  localparam int T  = 8;

  logic          clk = 1'b0;
  logic          reset = 1'b0;
  logic [7:0]    rx_data = 8'h00;
  logic          rx_valid = 1'b0;
  logic          tx_req = 1'b0;
  logic [7:0]    tx_data;
  logic [AW-1:0] host_addr = '0;
  logic          host_we = 1'b0;
  logic [7:0]    host_wdata = 8'h00;
  logic [7:0]    host_rdata;
  logic          wr_strobe;
  logic [AW-1:0] wr_addr;
  logic [AW-1:0] ptr;

  i2c_reg_bridge #(.ADDR_W(AW), .TIMEOUT(T)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_req(tx_req), .tx_data(tx_data), .host_addr(host_addr),
    .host_we(host_we), .host_wdata(host_wdata), .host_rdata(host_rdata),
    .wr_strobe(wr_strobe), .wr_addr(wr_addr), .ptr(ptr)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  int tests = 0;
  int fails = 0;

  // Reference model: byte-level view of the protocol.
  logic [7:0] mreg [16];
  logic [3:0] mptr;
  bit         mptr_mode;
  int         last_evt;

  task automatic chk(input string name, input logic [15:0] act, input logic [15:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic model_reset();
    for (int i = 0; i < 16; i++) mreg[i] = 8'h00;
    mptr      = 4'd0;
    mptr_mode = 1'b1;
    last_evt  = cyc;
  endtask

  // Idle clocks between two byte events decide whether the pointer phase restarts.
  task automatic model_event(input int rise);
    if (rise - last_evt - 1 >= T) mptr_mode = 1'b1;
    last_evt = rise;
  endtask

  task automatic do_reset(input int n);
    reset = 1'b0;
    step(n);
    reset = 1'b1;
    model_reset();
  endtask

  task automatic send_rx(input logic [7:0] b, input bit hw, input logic [3:0] ha,
                         input logic [7:0] hd, input bit with_tx);
    int rise;
    bit wr;
    logic [3:0] wa;
    rx_data  = b;
    rx_valid = 1'b1;
    tx_req   = with_tx;
    rise     = cyc + 1;
    step(1);
    rx_valid   = 1'b0;
    tx_req     = 1'b0;
    host_we    = hw;
    host_addr  = ha;
    host_wdata = hd;
    step(1);
    host_we = 1'b0;
    model_event(rise);
    wr = 1'b0;
    wa = 4'd0;
    if (mptr_mode) begin
      mptr      = b[3:0];
      mptr_mode = 1'b0;
    end else begin
      wr       = 1'b1;
      wa       = mptr;
      mreg[wa] = b;
      mptr     = mptr + 4'd1;
    end
    if (hw && !(wr && ha == wa)) mreg[ha] = hd;
    chk("rx wr_strobe", 16'(wr_strobe), 16'(wr));
    if (wr) chk("rx wr_addr", 16'(wr_addr), 16'(wa));
    chk("rx ptr", 16'(ptr), 16'(mptr));
    chk("rx tx_data", 16'(tx_data), 16'(mreg[mptr]));
  endtask

  task automatic send_tx();
    int rise;
    tx_req = 1'b1;
    rise   = cyc + 1;
    step(1);
    tx_req = 1'b0;
    step(1);
    model_event(rise);
    mptr = mptr + 4'd1;
    chk("tx wr_strobe", 16'(wr_strobe), 16'd0);
    chk("tx ptr", 16'(ptr), 16'(mptr));
    chk("tx tx_data", 16'(tx_data), 16'(mreg[mptr]));
  endtask

  task automatic host_read(input logic [3:0] a, output logic [7:0] d);
    host_addr = a;
    step(1);
    d = host_rdata;
  endtask

  typedef struct {
    bit         is_tx;
    logic [7:0] dat;
    int         pre;
    logic [3:0] e_ptr;
    bit         e_stb;
    logic [3:0] e_wa;
    logic [7:0] e_tx;
  } vec_t;

  vec_t vt[18];

  initial begin
    logic [7:0] rd;
    vt[0]  = '{1'b0, 8'h03, 0,   4'd3,  1'b0, 4'd0,  8'h00};
    vt[1]  = '{1'b0, 8'hA5, 0,   4'd4,  1'b1, 4'd3,  8'h00};
    vt[2]  = '{1'b0, 8'h5A, 0,   4'd5,  1'b1, 4'd4,  8'h00};
    vt[3]  = '{1'b0, 8'hFF, T,   4'd15, 1'b0, 4'd0,  8'h00};
    vt[4]  = '{1'b0, 8'h11, 0,   4'd0,  1'b1, 4'd15, 8'h00};
    vt[5]  = '{1'b0, 8'h22, 0,   4'd1,  1'b1, 4'd0,  8'h00};
    vt[6]  = '{1'b0, 8'h02, T,   4'd2,  1'b0, 4'd0,  8'h00};
    vt[7]  = '{1'b0, 8'h10, 0,   4'd3,  1'b1, 4'd2,  8'hA5};
    vt[8]  = '{1'b0, 8'h20, 0,   4'd4,  1'b1, 4'd3,  8'h5A};
    vt[9]  = '{1'b0, 8'h30, 0,   4'd5,  1'b1, 4'd4,  8'h00};
    vt[10] = '{1'b0, 8'h02, T,   4'd2,  1'b0, 4'd0,  8'h10};
    vt[11] = '{1'b1, 8'h00, 0,   4'd3,  1'b0, 4'd0,  8'h20};
    vt[12] = '{1'b1, 8'h00, 0,   4'd4,  1'b0, 4'd0,  8'h30};
    vt[13] = '{1'b1, 8'h00, 0,   4'd5,  1'b0, 4'd0,  8'h00};
    vt[14] = '{1'b0, 8'h07, T-2, 4'd6,  1'b1, 4'd5,  8'h00};
    vt[15] = '{1'b0, 8'h07, T,   4'd7,  1'b0, 4'd0,  8'h00};
    vt[16] = '{1'b0, 8'h44, 0,   4'd8,  1'b1, 4'd7,  8'h00};
    vt[17] = '{1'b0, 8'h0A, T-1, 4'd10, 1'b0, 4'd0,  8'h00};

    step(1);
    do_reset(2);
    chk("reset ptr", 16'(ptr), 16'd0);
    chk("reset tx_data", 16'(tx_data), 16'd0);
    chk("reset wr_strobe", 16'(wr_strobe), 16'd0);
    chk("reset wr_addr", 16'(wr_addr), 16'd0);
    chk("reset host_rdata", 16'(host_rdata), 16'd0);

    for (int i = 0; i < 18; i++) begin
      step(vt[i].pre);
      if (vt[i].is_tx) send_tx();
      else send_rx(vt[i].dat, 1'b0, 4'd0, 8'h00, 1'b0);
      chk($sformatf("vec%0d ptr", i), 16'(ptr), 16'(vt[i].e_ptr));
      chk($sformatf("vec%0d wr_strobe", i), 16'(wr_strobe), 16'(vt[i].e_stb));
      if (vt[i].e_stb) chk($sformatf("vec%0d wr_addr", i), 16'(wr_addr), 16'(vt[i].e_wa));
      chk($sformatf("vec%0d tx_data", i), 16'(tx_data), 16'(vt[i].e_tx));
    end
    host_read(4'd15, rd); chk("reg15 after wrap", 16'(rd), 16'h11);
    host_read(4'd0, rd);  chk("reg0 after wrap", 16'(rd), 16'h22);
    host_read(4'd5, rd);  chk("reg5 timeout data", 16'(rd), 16'h07);

    // Same-index collision: the I2C byte wins; different index: both land.
    send_rx(8'h99, 1'b1, 4'd10, 8'h44, 1'b0);
    host_read(4'd10, rd); chk("collision reg", 16'(rd), 16'h99);
    send_rx(8'h12, 1'b1, 4'd3, 8'h66, 1'b0);
    host_read(4'd11, rd); chk("split i2c reg", 16'(rd), 16'h12);
    host_read(4'd3, rd);  chk("split host reg", 16'(rd), 16'h66);

    host_addr = 4'd2; host_we = 1'b1; host_wdata = 8'hEE;
    step(1);
    host_we = 1'b0;
    chk("read-during-write old", 16'(host_rdata), 16'h10);
    mreg[2] = 8'hEE;
    step(1);
    chk("read after write", 16'(host_rdata), 16'hEE);

    // Reset with rx_valid held high mid-transfer.
    send_rx(8'h05, 1'b0, 4'd0, 8'h00, 1'b0);
    step(T);
    send_rx(8'h05, 1'b0, 4'd0, 8'h00, 1'b0);
    send_rx(8'hAB, 1'b0, 4'd0, 8'h00, 1'b0);
    rx_data = 8'hCD; rx_valid = 1'b1;
    step(1);
    do_reset(2);
    chk("midreset ptr", 16'(ptr), 16'd0);
    chk("midreset wr_strobe", 16'(wr_strobe), 16'd0);
    chk("midreset tx_data", 16'(tx_data), 16'd0);
    step(3);
    chk("held rx_valid ptr", 16'(ptr), 16'd0);
    chk("held rx_valid strobe", 16'(wr_strobe), 16'd0);
    host_read(4'd5, rd); chk("midreset reg5 cleared", 16'(rd), 16'h00);
    rx_valid = 1'b0;
    step(1);
    send_rx(8'h09, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("post-reset pointer", 16'(ptr), 16'd9);
    send_rx(8'h77, 1'b0, 4'd0, 8'h00, 1'b0);
    chk("post-reset data addr", 16'(wr_addr), 16'd9);

    // Randomized traffic against the model.
    do_reset(1);
    for (int n = 0; n < 400; n++) begin
      int r;
      int pre;
      bit hw;
      logic [3:0] ha;
      r   = $urandom_range(0, 99);
      pre = ($urandom_range(0, 9) == 0) ? $urandom_range(T - 2, T + 2) : $urandom_range(0, 3);
      step(pre);
      hw = ($urandom_range(0, 2) == 0);
      ha = ($urandom_range(0, 2) == 0) ? mptr : 4'($urandom_range(0, 15));
      if (r < 60) send_rx(8'($urandom_range(0, 255)), hw, ha, 8'($urandom_range(0, 255)), 1'b0);
      else if (r < 85) send_tx();
      else if (r < 92) send_rx(8'($urandom_range(0, 255)), 1'b0, 4'd0, 8'h00, 1'b1);
      else begin
        host_read(ha, rd);
        chk("random host read", 16'(rd), 16'(mreg[ha]));
      end
    end
    for (int a = 0; a < 16; a++) begin
      host_read(4'(a), rd);
      chk($sformatf("final reg%0d", a), 16'(rd), 16'(mreg[a]));
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
